// File: rtl/addsub_pkg.sv
// Shared FSM state encoding and operation-mode constants for the serial add/sub unit.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/ha_cell.sv
// Combinational half adder; two of these plus a carry register form the serial full adder.
module ha_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial adder/subtractor, LSB first, one result bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    import addsub_pkg::*;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t          state;
    state_t          next_state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic            c;
    logic [CW-1:0]   bitcnt;
    logic            accept;
    logic            last_bit;
    logic            ha1_sum;
    logic            ha1_carry;
    logic            bit_sum;
    logic            ha2_carry;
    logic            carry_next;

    ha_cell u_ha1 (
        .a     (sa[0]),
        .b     (sb[0]),
        .sum   (ha1_sum),
        .carry (ha1_carry)
    );

    ha_cell u_ha2 (
        .a     (ha1_sum),
        .b     (c),
        .sum   (bit_sum),
        .carry (ha2_carry)
    );

    assign carry_next = ha1_carry | ha2_carry;
    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign last_bit   = (bitcnt == LAST_BIT);
    assign busy       = (state == SHIFT);
    assign done       = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (last_bit) next_state = DONE;
            DONE:    next_state = start ? SHIFT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert b on load and seed the carry with the mode bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            c      <= 1'b0;
            bitcnt <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            sa     <= a;
            sb     <= (mode == MODE_SUB) ? ~b : b;
            c      <= mode;
            bitcnt <= '0;
            result <= '0;
        end else if (state == SHIFT) begin
            c      <= carry_next;
            result <= {bit_sum, result[WIDTH-1:1]};
            sa     <= {1'b0, sa[WIDTH-1:1]};
            sb     <= {1'b0, sb[WIDTH-1:1]};
            bitcnt <= bitcnt + CW'(1);
            if (last_bit) begin
                cout <= carry_next;
            end
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    // On the final bit, c still holds the carry into the MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (!accept && (state == SHIFT) && last_bit) begin
            ovf <= c ^ carry_next;
        end
    end
`endif

endmodule
